brick_pixel_plotter: RTL and testbench
======================================

BRICK_PIXEL_PLOTTER -- requirements
Module: brick_pixel_plotter

Interface
REQ-001 Parameter BRICK_W, default 10, brick width in pixels.
REQ-002 Parameter BRICK_H, default 5, brick height in pixels.
REQ-003 Parameter SCREEN_W, default 160; SCREEN_H, default 120; visible raster bounds.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 req_valid  input  1  brick-origin request strobe from the brick draw sequencer.
REQ-007 req_x  input  10  brick origin column.
REQ-008 req_y  input  10  brick origin row.
REQ-009 req_colour  input  3  brick fill colour.
REQ-010 req_ready  output  1  request buffer can accept a request this cycle.
REQ-011 plot  output  1  VGA adapter write enable for the current pixel.
REQ-012 vga_x  output  8  pixel column.
REQ-013 vga_y  output  7  pixel row.
REQ-014 vga_colour  output  3  pixel colour.
REQ-015 busy  output  1  high when the FSM is not in IDLE or the buffer is non-empty.
REQ-016 done  output  1  one-cycle pulse marking the final pixel cycle of each brick.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_valid while req_ready=0 SHALL be dropped.
REQ-018 The request buffer SHALL be a 2-entry FIFO of {req_x, req_y, req_colour}; req_ready = (count < 2), evaluated before the edge.
REQ-019 The FSM SHALL have states IDLE, LOAD, PLOT.
REQ-020 IDLE -> LOAD when the FIFO is non-empty; otherwise stay in IDLE.
REQ-021 LOAD (one cycle, plot=0) SHALL pop the FIFO head on the exiting edge, latch origin and colour, clear cx and cy, and go to PLOT.
REQ-022 PLOT SHALL emit one pixel per cycle: sx = origin_x + cx and sy = origin_y + cy, 11-bit sums; cx counts 0..BRICK_W-1, then wraps to 0 and increments cy; row-major order.
REQ-023 The pixel at cx=BRICK_W-1, cy=BRICK_H-1 SHALL assert done in the same cycle; the next state SHALL be IDLE.
REQ-024 A brick SHALL occupy exactly BRICK_W*BRICK_H PLOT cycles (50 at defaults), independent of clipping.
REQ-025 Clipping: plot = PLOT and sx < SCREEN_W and sy < SCREEN_H; off-screen pixels consume a cycle with plot=0.
REQ-026 vga_x SHALL be sx[7:0] and vga_y SHALL be sy[6:0] in PLOT; vga_colour SHALL be the latched colour.
REQ-027 In IDLE and LOAD, vga_x, vga_y and vga_colour SHALL be 0, and plot and done SHALL be 0.
REQ-028 Latency: a request accepted at edge k into an empty FIFO with the FSM in IDLE SHALL produce LOAD after edge k+1 and the first pixel after edge k+2.
REQ-029 A push and a pop on the same edge SHALL leave count unchanged, with the new entry queued behind the remaining entries; FIFO order SHALL be preserved.
REQ-030 A fully clipped brick (e.g. req_x >= 160) SHALL still run 50 cycles and pulse done.

Reset
REQ-031 With resetn=0 at a rising edge: state=IDLE, FIFO empty, cx=cy=0, latched origin and colour=0.
REQ-032 Outputs after reset: req_ready=1, busy=0, plot=0, done=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-033 Reset during PLOT SHALL abandon the brick with no done pulse and SHALL discard queued requests.

Verification
REQ-034 Single request (20,10,3'b100): LOAD at k+1; 50 pixels with x 20..29 and y 10..14 row-major, colour 4 and plot=1 throughout; done only at (29,14); busy low on the following cycle.
REQ-035 req_valid held for 3 consecutive edges k..k+2 with origins A, B, C: A and B accepted; C dropped (req_ready=0 at k+2, count=2); A then B drawn, one IDLE cycle between bricks; done pulses twice.
REQ-036 Clip request (155,118): plot=1 only for x 155..159 and y 118..119 (10 pixels); 50 PLOT cycles; done asserted.
REQ-037 Full clip request (200,0): plot never asserted; done pulses after 50 PLOT cycles.
REQ-038 resetn=0 at the 20th pixel with one request queued: next cycle plot=0, busy=0, req_ready=1, no done, and the queued request is never drawn.
REQ-039 Request accepted at the same edge the FSM pops (count 1 -> 1): both bricks are drawn in acceptance order.

Source files
------------

// File: rtl/brick_pixel_plotter.sv
// -----------------------------------------------------------------------------
// BrickPixelPlotter
//
// Purpose:
//   Takes brick-origin requests from the brick draw sequencer. Requests wait in
//   a 2-entry FIFO. A small IDLE/LOAD/PLOT state machine then walks every pixel
//   of a BRICK_W x BRICK_H brick in row-major order, one pixel per clock. Pixels
//   that land outside the visible raster still take their cycle, but their
//   VGA write enable (plot) is held low.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   resetn       synchronous, active-low reset
//   req_valid    request strobe; accepted only while req_ready is high
//   req_x/req_y  10-bit brick origin column / row
//   req_colour   3-bit brick fill colour
//   req_ready    request FIFO has room (fewer than two entries queued)
//   plot         VGA adapter write enable for the current pixel
//   vga_x/vga_y  current pixel column (8 bits) / row (7 bits)
//   vga_colour   current pixel colour
//   busy         engine not idle, or requests still queued
//   done         one-cycle pulse on the final pixel cycle of each brick
// -----------------------------------------------------------------------------
module brick_pixel_plotter #(
    parameter int BRICK_W  = 10,
    parameter int BRICK_H  = 5,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [9:0] req_x,
    input  logic [9:0] req_y,
    input  logic [2:0] req_colour,
    output logic       req_ready,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLOT = 2'd2
    } state_t;

    localparam logic [9:0]  CX_LAST     = 10'(BRICK_W - 1);
    localparam logic [9:0]  CY_LAST     = 10'(BRICK_H - 1);
    localparam logic [10:0] SCREEN_W_11 = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_11 = 11'(SCREEN_H);

    // Request FIFO storage: {x, y, colour}
    logic [22:0] fifoMem_q [2];
    logic        wrPtr_q;
    logic        rdPtr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    // Drawing engine state
    state_t      state_q;
    state_t      state_d;
    logic [9:0]  cx_q;
    logic [9:0]  cx_d;
    logic [9:0]  cy_q;
    logic [9:0]  cy_d;
    logic [9:0]  originX_q;
    logic [9:0]  originX_d;
    logic [9:0]  originY_q;
    logic [9:0]  originY_d;
    logic [2:0]  colour_q;
    logic [2:0]  colour_d;

    logic        push;
    logic        pop;
    logic [22:0] fifoHead;
    logic [10:0] sx;
    logic [10:0] sy;
    logic        lastPixel;

    assign req_ready = (count_q < 2'd2);
    assign push      = req_valid && req_ready;
    assign fifoHead  = fifoMem_q[rdPtr_q];

    // Screen coordinates are 11-bit sums so that an origin near 1023 cannot
    // wrap back on screen; the clip test below uses the full width.
    assign sx        = {1'b0, originX_q} + {1'b0, cx_q};
    assign sy        = {1'b0, originY_q} + {1'b0, cy_q};
    assign lastPixel = (cx_q == CX_LAST) && (cy_q == CY_LAST);

    assign busy      = (state_q != IDLE) || (count_q != 2'd0);

    // Occupancy only moves when exactly one of push/pop happens. Because
    // req_ready excludes pushing into a full FIFO, count never exceeds 2.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // The FIFO payload needs no reset; occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {req_x, req_y, req_colour};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            count_q   <= 2'd0;
            state_q   <= IDLE;
            cx_q      <= 10'd0;
            cy_q      <= 10'd0;
            originX_q <= 10'd0;
            originY_q <= 10'd0;
            colour_q  <= 3'd0;
        end else begin
            if (push) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q   <= count_d;
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            originX_q <= originX_d;
            originY_q <= originY_d;
            colour_q  <= colour_d;
        end
    end

    // Next-state and pixel outputs. LOAD pops the head and latches it on its
    // exiting edge. PLOT scans cx fastest, then cy. The final pixel raises
    // done and returns to IDLE, so two back-to-back bricks always have one
    // IDLE cycle between them.
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        originX_d  = originX_q;
        originY_d  = originY_q;
        colour_d   = colour_q;
        pop        = 1'b0;
        plot       = 1'b0;
        done       = 1'b0;
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;

        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                pop       = 1'b1;
                originX_d = fifoHead[22:13];
                originY_d = fifoHead[12:3];
                colour_d  = fifoHead[2:0];
                cx_d      = 10'd0;
                cy_d      = 10'd0;
                state_d   = PLOT;
            end

            PLOT: begin
                plot       = (sx < SCREEN_W_11) && (sy < SCREEN_H_11);
                vga_x      = sx[7:0];
                vga_y      = sy[6:0];
                vga_colour = colour_q;
                if (lastPixel) begin
                    done    = 1'b1;
                    cx_d    = 10'd0;
                    cy_d    = 10'd0;
                    state_d = IDLE;
                end else if (cx_q == CX_LAST) begin
                    cx_d = 10'd0;
                    cy_d = cy_q + 10'd1;
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_brick_pixel_plotter.sv
// -----------------------------------------------------------------------------
// tb_brick_pixel_plotter
//
// Purpose:
//   Self-checking bench for BrickPixelPlotter. The reference model is at the
//   transaction level. It keeps a queue of accepted requests, and a schedule
//   of the outputs expected in the cycles ahead. When the engine is free and a
//   request is waiting, the schedule gains one LOAD cycle followed by the
//   brick's pixels, computed directly from origin + offset.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_brick_pixel_plotter;

    localparam int BW = 10;
    localparam int BH = 5;
    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic [9:0] req_x;
    logic [9:0] req_y;
    logic [2:0] req_colour;
    logic       req_ready;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    brick_pixel_plotter #(
        .BRICK_W (BW),
        .BRICK_H (BH),
        .SCREEN_W(SW),
        .SCREEN_H(SH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_colour(req_colour),
        .req_ready (req_ready),
        .plot      (plot),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        bit isLoad;
        bit plot;
        int x;
        int y;
        int col;
        bit done;
        int idx;
    } cycle_t;

    typedef struct {
        int x;
        int y;
        int col;
    } request_t;

    cycle_t   sched[$];
    request_t pending[$];

    int compared   = 0;
    int mismatched = 0;
    int plotCount  = 0;
    int doneCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Appends one brick to the schedule: a LOAD cycle, then every pixel.
    task automatic scheduleBrick(input request_t r);
        cycle_t c;
        c = '{isLoad: 1'b1, plot: 1'b0, x: 0, y: 0, col: 0, done: 1'b0, idx: -1};
        sched.push_back(c);
        for (int row = 0; row < BH; row++) begin
            for (int col = 0; col < BW; col++) begin
                int sx = r.x + col;
                int sy = r.y + row;
                c.isLoad = 1'b0;
                c.plot   = (sx < SW) && (sy < SH);
                c.x      = sx % 256;
                c.y      = sy % 128;
                c.col    = r.col;
                c.done   = (row == BH - 1) && (col == BW - 1);
                c.idx    = row * BW + col;
                sched.push_back(c);
            end
        end
    endtask

    // Advances the model across one rising edge, using the inputs the DUT sees.
    task automatic modelEdge();
        bit       engineIdle;
        bit       canAccept;
        cycle_t   finished;
        request_t r;
        engineIdle = (sched.size() == 0);
        canAccept  = (pending.size() < 2);
        if (!resetn) begin
            sched.delete();
            pending.delete();
            return;
        end
        if (!engineIdle) begin
            finished = sched.pop_front();
            if (finished.isLoad) begin
                void'(pending.pop_front());
            end
        end else if (pending.size() > 0) begin
            scheduleBrick(pending[0]);
        end
        if (req_valid && canAccept) begin
            r.x   = int'(req_x);
            r.y   = int'(req_y);
            r.col = int'(req_colour);
            pending.push_back(r);
        end
    endtask

    task automatic checkOutputs();
        cycle_t e;
        e = '{isLoad: 1'b0, plot: 1'b0, x: 0, y: 0, col: 0, done: 1'b0, idx: -1};
        if (sched.size() > 0) begin
            e = sched[0];
        end
        checkOutput("plot", 32'(plot), 32'(e.plot));
        checkOutput("vga_x", 32'(vga_x), e.x);
        checkOutput("vga_y", 32'(vga_y), e.y);
        checkOutput("vga_colour", 32'(vga_colour), e.col);
        checkOutput("done", 32'(done), 32'(e.done));
        checkOutput("busy", 32'(busy), 32'((sched.size() > 0) || (pending.size() > 0)));
        checkOutput("req_ready", 32'(req_ready), 32'(pending.size() < 2));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutputs();
        plotCount += int'(plot);
        doneCount += int'(done);
    endtask

    task automatic applyStimulus(input logic v, input int x, input int y, input int c);
        req_valid  = v;
        req_x      = 10'(x);
        req_y      = 10'(y);
        req_colour = 3'(c);
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        applyStimulus(1'b0, 0, 0, 0);
        while (((sched.size() > 0) || (pending.size() > 0)) && (n < maxCycles)) begin
            tick();
            n++;
        end
        if (n >= maxCycles) begin
            checkOutput("drain_timeout", 32'(n), 32'(0));
        end
        tick();
    endtask

    task automatic clearCounts();
        plotCount = 0;
        doneCount = 0;
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, 0, 0, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Single brick at (20,10), colour 4
        clearCounts();
        applyStimulus(1'b1, 20, 10, 4);
        tick();
        drain(200);
        checkOutput("single_plots", 32'(plotCount), 32'd50);
        checkOutput("single_dones", 32'(doneCount), 32'd1);

        // Three consecutive requests: the third is dropped on a full FIFO
        clearCounts();
        applyStimulus(1'b1, 0, 0, 1);
        tick();
        applyStimulus(1'b1, 40, 30, 2);
        tick();
        applyStimulus(1'b1, 80, 60, 3);
        tick();
        drain(400);
        checkOutput("burst_dones", 32'(doneCount), 32'd2);
        checkOutput("burst_plots", 32'(plotCount), 32'd100);

        // Partial clip at the bottom-right corner
        clearCounts();
        applyStimulus(1'b1, 155, 118, 5);
        tick();
        drain(200);
        checkOutput("clip_plots", 32'(plotCount), 32'd10);
        checkOutput("clip_dones", 32'(doneCount), 32'd1);

        // Fully off-screen brick
        clearCounts();
        applyStimulus(1'b1, 200, 0, 6);
        tick();
        drain(200);
        checkOutput("fullclip_plots", 32'(plotCount), 32'd0);
        checkOutput("fullclip_dones", 32'(doneCount), 32'd1);

        // Reset on the 20th pixel with one request still queued
        begin
            int n = 0;
            clearCounts();
            applyStimulus(1'b1, 10, 10, 7);
            tick();
            applyStimulus(1'b1, 60, 50, 2);
            tick();
            applyStimulus(1'b0, 0, 0, 0);
            while (!((sched.size() > 0) && !sched[0].isLoad && (sched[0].idx == 19)) && (n < 100)) begin
                tick();
                n++;
            end
            if (n >= 100) begin
                checkOutput("reset_wait_timeout", 32'(n), 32'd0);
            end
            resetn = 1'b0;
            tick();
            resetn = 1'b1;
            checkOutput("reset_plot", 32'(plot), 32'd0);
            checkOutput("reset_busy", 32'(busy), 32'd0);
            checkOutput("reset_ready", 32'(req_ready), 32'd1);
            clearCounts();
            for (int i = 0; i < 120; i++) begin
                tick();
            end
            checkOutput("reset_no_plots", 32'(plotCount), 32'd0);
            checkOutput("reset_no_dones", 32'(doneCount), 32'd0);
        end

        // A push on the same edge as the LOAD pop keeps count at one
        begin
            int n = 0;
            clearCounts();
            applyStimulus(1'b1, 30, 20, 3);
            tick();
            applyStimulus(1'b0, 0, 0, 0);
            while (!((sched.size() > 0) && sched[0].isLoad) && (n < 10)) begin
                tick();
                n++;
            end
            if (n >= 10) begin
                checkOutput("load_wait_timeout", 32'(n), 32'd0);
            end
            applyStimulus(1'b1, 100, 90, 6);
            tick();
            checkOutput("pushpop_busy", 32'(busy), 32'd1);
            drain(400);
            checkOutput("pushpop_dones", 32'(doneCount), 32'd2);
        end

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int x;
            int y;
            x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 170));
            y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 125));
            applyStimulus(($urandom_range(0, 2) == 0), x, y, int'($urandom_range(0, 7)));
            resetn = ($urandom_range(0, 399) != 0);
            tick();
        end
        resetn = 1'b1;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
